// File: rtl/demux1_4_tdm_if.sv
// Shared-line bundle for the 4-slot TDM receiver.
// Line side drives din/din_valid/fsync; the demux returns frame status.
interface demux1_4_tdm_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               fsync;
    logic [4*WIDTH-1:0] dataout;
    logic               frame_valid;
    logic [1:0]         sel;
    logic               locked;
    logic               err;

    modport master (
        output din, din_valid, fsync,
        input  dataout, frame_valid, sel, locked, err
    );

    modport slave (
        input  din, din_valid, fsync,
        output dataout, frame_valid, sel, locked, err
    );
endinterface

// File: rtl/demux1_4_tdm.sv
// 1:4 time-division demultiplexer with frame lock and flywheel.
// Slots are staged, then all four channels land in dataout on one edge.
module demux1_4_tdm #(
    parameter int WIDTH      = 8,
    parameter int MISS_LIMIT = 3
) (
    input logic           clk,
    input logic           rst_n,
    demux1_4_tdm_if.slave bus
);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [MW-1:0]      miss_q, miss_d, miss_inc;
    logic [WIDTH-1:0]   stg0_q, stg0_d;
    logic [WIDTH-1:0]   stg1_q, stg1_d;
    logic [WIDTH-1:0]   stg2_q, stg2_d;
    logic [4*WIDTH-1:0] dout_q, dout_d;
    logic               fv_q, fv_d;
    logic               err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            sel_q   <= '0;
            miss_q  <= '0;
            stg0_q  <= '0;
            stg1_q  <= '0;
            stg2_q  <= '0;
            dout_q  <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            miss_q  <= miss_d;
            stg0_q  <= stg0_d;
            stg1_q  <= stg1_d;
            stg2_q  <= stg2_d;
            dout_q  <= dout_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        miss_d   = miss_q;
        stg0_d   = stg0_q;
        stg1_d   = stg1_q;
        stg2_d   = stg2_q;
        dout_d   = dout_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        miss_inc = miss_q + MW'(1);

        if (bus.din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.fsync) begin
                        stg0_d  = bus.din;
                        sel_d   = 2'd1;
                        miss_d  = '0;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (bus.fsync) begin
                        // A sync anywhere restarts the frame; mid-frame it is an error.
                        err_d  = (sel_q != 2'd0);
                        stg0_d = bus.din;
                        sel_d  = 2'd1;
                        miss_d = '0;
                    end else begin
                        unique case (sel_q)
                            2'd0: begin
                                err_d  = 1'b1;
                                miss_d = miss_inc;
                                if (miss_inc == MW'(MISS_LIMIT)) begin
                                    state_d = HUNT;
                                    sel_d   = 2'd0;
                                end else begin
                                    stg0_d = bus.din;
                                    sel_d  = 2'd1;
                                end
                            end
                            2'd1: begin
                                stg1_d = bus.din;
                                sel_d  = 2'd2;
                            end
                            2'd2: begin
                                stg2_d = bus.din;
                                sel_d  = 2'd3;
                            end
                            2'd3: begin
                                dout_d = {bus.din, stg2_q, stg1_q, stg0_q};
                                fv_d   = 1'b1;
                                sel_d  = 2'd0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.dataout     = dout_q;
    assign bus.frame_valid = fv_q;
    assign bus.sel         = sel_q;
    assign bus.locked      = (state_q == LOCK);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_demux1_4_tdm.sv
// Bench for demux1_4_tdm: directed vector table, reset corner case,
// then random beats against a slot-level reference model.
module tb_demux1_4_tdm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    demux1_4_tdm_if #(.WIDTH(8)) bus ();

    demux1_4_tdm #(.WIDTH(8), .MISS_LIMIT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          v;
        bit          fs;
        logic [7:0]  d;
        bit          fv;
        bit          er;
        bit          lk;
        logic [1:0]  sl;
        logic [31:0] dout;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit v, input bit fs, input logic [7:0] d,
                       input bit fv, input bit er, input bit lk,
                       input logic [1:0] sl, input logic [31:0] dout);
        vec_t r;
        r.v = v; r.fs = fs; r.d = d; r.fv = fv; r.er = er;
        r.lk = lk; r.sl = sl; r.dout = dout;
        vq.push_back(r);
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit fv, input bit er,
                             input bit lk, input logic [1:0] sl,
                             input logic [31:0] dout);
        check({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'(fv));
        check({tag, ".err"}, 32'(bus.err), 32'(er));
        check({tag, ".locked"}, 32'(bus.locked), 32'(lk));
        check({tag, ".sel"}, 32'(bus.sel), 32'(sl));
        check({tag, ".dataout"}, bus.dataout, dout);
    endtask

    task automatic beat(input bit r, input bit v, input bit fs,
                        input logic [7:0] d);
        @(negedge clk);
        rst_n = r;
        bus.din_valid = v;
        bus.fsync = fs;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: slot position in a frame, -1 while hunting.
    int          m_slot;
    int          m_miss;
    logic [7:0]  m_ch[4];
    logic [31:0] m_dout;
    bit          m_fv;
    bit          m_err;

    task automatic m_reset();
        m_slot = -1; m_miss = 0; m_dout = '0; m_fv = 0; m_err = 0;
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
    endtask

    task automatic m_step(input bit r, input bit v, input bit fs,
                          input logic [7:0] d);
        m_fv = 0;
        m_err = 0;
        if (!r) begin
            m_reset();
        end else if (v) begin
            if (m_slot < 0) begin
                if (fs) begin
                    m_ch[0] = d; m_slot = 1; m_miss = 0;
                end
            end else if (fs) begin
                m_err = (m_slot != 0);
                m_ch[0] = d; m_slot = 1; m_miss = 0;
            end else if (m_slot == 0) begin
                m_err = 1;
                m_miss++;
                if (m_miss >= 3) m_slot = -1;
                else begin
                    m_ch[0] = d; m_slot = 1;
                end
            end else begin
                m_ch[m_slot] = d;
                if (m_slot == 3) begin
                    m_dout = {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
                    m_fv = 1;
                    m_slot = 0;
                end else begin
                    m_slot++;
                end
            end
        end
    endtask

    initial begin
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.fsync = 1'b0;

        // basic frame
        add(1,1,8'h11, 0,0,1,1, 32'h0);
        add(1,0,8'h22, 0,0,1,2, 32'h0);
        add(1,0,8'h33, 0,0,1,3, 32'h0);
        add(1,0,8'h44, 1,0,1,0, 32'h44332211);
        // gaps inside a frame
        add(0,0,8'hEE, 0,0,1,0, 32'h44332211);
        add(1,1,8'hA0, 0,0,1,1, 32'h44332211);
        add(0,1,8'hEE, 0,0,1,1, 32'h44332211);
        add(1,0,8'hA1, 0,0,1,2, 32'h44332211);
        add(0,0,8'hEE, 0,0,1,2, 32'h44332211);
        add(1,0,8'hA2, 0,0,1,3, 32'h44332211);
        add(1,0,8'hA3, 1,0,1,0, 32'hA3A2A1A0);
        // early sync on slot 2
        add(1,1,8'h01, 0,0,1,1, 32'hA3A2A1A0);
        add(1,0,8'h02, 0,0,1,2, 32'hA3A2A1A0);
        add(1,1,8'h55, 0,1,1,1, 32'hA3A2A1A0);
        add(1,0,8'h66, 0,0,1,2, 32'hA3A2A1A0);
        add(1,0,8'h77, 0,0,1,3, 32'hA3A2A1A0);
        add(1,0,8'h88, 1,0,1,0, 32'h88776655);
        // three frames without fsync
        add(1,0,8'hB0, 0,1,1,1, 32'h88776655);
        add(1,0,8'hB1, 0,0,1,2, 32'h88776655);
        add(1,0,8'hB2, 0,0,1,3, 32'h88776655);
        add(1,0,8'hB3, 1,0,1,0, 32'hB3B2B1B0);
        add(1,0,8'hC0, 0,1,1,1, 32'hB3B2B1B0);
        add(1,0,8'hC1, 0,0,1,2, 32'hB3B2B1B0);
        add(1,0,8'hC2, 0,0,1,3, 32'hB3B2B1B0);
        add(1,0,8'hC3, 1,0,1,0, 32'hC3C2C1C0);
        add(1,0,8'hD0, 0,1,0,0, 32'hC3C2C1C0);
        // hunting: unsynced beats ignored without err
        add(1,0,8'hD1, 0,0,0,0, 32'hC3C2C1C0);
        add(1,0,8'hD2, 0,0,0,0, 32'hC3C2C1C0);
        add(1,0,8'hD3, 0,0,0,0, 32'hC3C2C1C0);
        add(1,1,8'hA0, 0,0,1,1, 32'hC3C2C1C0);
        add(1,0,8'hA1, 0,0,1,2, 32'hC3C2C1C0);
        add(1,0,8'hA2, 0,0,1,3, 32'hC3C2C1C0);
        add(1,0,8'hA3, 1,0,1,0, 32'hA3A2A1A0);
        // back-to-back early syncs
        add(1,1,8'h10, 0,0,1,1, 32'hA3A2A1A0);
        add(1,1,8'h11, 0,1,1,1, 32'hA3A2A1A0);
        add(1,1,8'h12, 0,1,1,1, 32'hA3A2A1A0);
        add(1,0,8'h13, 0,0,1,2, 32'hA3A2A1A0);
        add(1,0,8'h14, 0,0,1,3, 32'hA3A2A1A0);
        add(1,0,8'h15, 1,0,1,0, 32'h15141312);

        beat(0, 0, 0, 8'h00);
        beat(0, 1, 1, 8'h99);
        check_all("reset", 0, 0, 0, 2'd0, 32'h0);

        foreach (vq[i]) begin
            beat(1, vq[i].v, vq[i].fs, vq[i].d);
            check_all($sformatf("vec%0d", i), vq[i].fv, vq[i].er,
                      vq[i].lk, vq[i].sl, vq[i].dout);
        end

        // reset mid-frame at sel=2
        beat(1, 1, 1, 8'h21);
        beat(1, 1, 0, 8'h22);
        check_all("pre_rst", 0, 0, 1, 2'd2, 32'h15141312);
        beat(0, 1, 0, 8'h23);
        check_all("mid_rst", 0, 0, 0, 2'd0, 32'h0);
        beat(1, 1, 0, 8'h23);
        beat(1, 1, 0, 8'h24);
        check_all("post_rst", 0, 0, 0, 2'd0, 32'h0);

        // random beats against the model
        beat(0, 0, 0, 8'h00);
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            bit r, v, fs;
            logic [7:0] d;
            int sl;
            r  = ($urandom_range(0, 299) != 0);
            v  = ($urandom_range(0, 3) != 0);
            fs = ($urandom_range(0, 5) == 0);
            d  = 8'($urandom);
            m_step(r, v, fs, d);
            beat(r, v, fs, d);
            sl = (m_slot < 0) ? 0 : m_slot;
            check_all($sformatf("rnd%0d", n), m_fv, m_err, m_slot >= 0,
                      2'(sl), m_dout);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux1_4_tdm.md
Name: demux1_4_tdm

Overview:
Time-division demultiplexer: the receive end of the 4:1 shared-line channel multiplexer. It takes a single WIDTH-bit stream carrying four channels in fixed slot order (slot 0 marked by fsync). It locks onto the frame, de-interleaves the slots into four channel registers, and presents a complete, coherent 4-channel frame with a one-cycle strobe. Sits between the shared bus line and the per-channel consumers.

Parameters:
WIDTH, 8, bits per slot / per channel
MISS_LIMIT, 3, consecutive frames with fsync absent at slot 0 before lock is dropped (1..15)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
din  input  WIDTH  slot data from shared line
din_valid  input  1  din carries a slot beat this cycle
fsync  input  1  qualifies the current beat as slot 0; ignored unless din_valid=1
dataout  output  4*WIDTH  registered frame; dataout[WIDTH-1:0]=ch0 … [4*WIDTH-1:3*WIDTH]=ch3
frame_valid  output  1  one-cycle pulse: dataout just updated with a complete frame
sel  output  2  slot index expected for the next beat (0..3)
locked  output  1  1 when FSM in LOCK
err  output  1  one-cycle pulse on any framing error

Behaviour:
- Clock/reset: one clock; reset synchronous, active-low (rst_n sampled on clk rising edge). Reset has priority over all inputs.
- Reset values: dataout=0, frame_valid=0, sel=0, locked=0, err=0; state=HUNT; miss_cnt=0; staging regs stg0..stg2=0.
- FSM states: HUNT, LOCK. Nothing changes on cycles with din_valid=0, except frame_valid and err returning to 0.
- HUNT:
  - din_valid & !fsync: beat discarded, no err.
  - din_valid & fsync: stg0<=din, sel<=1, miss_cnt<=0, go to LOCK.
- LOCK, din_valid=1:
  - sel=0, fsync=1: stg0<=din, sel<=1, miss_cnt<=0.
  - sel=0, fsync=0 (flywheel): err pulse, miss_cnt+1.
    - If new miss_cnt < MISS_LIMIT: capture as slot 0 anyway, sel<=1.
    - If new miss_cnt = MISS_LIMIT: go to HUNT, beat discarded, sel<=0.
  - sel=1 or 2, fsync=0: stg[sel]<=din, sel<=sel+1.
  - sel=3, fsync=0: dataout<={din,stg2,stg1,stg0}, frame_valid=1 next cycle, sel<=0 (wrap).
  - sel≠0, fsync=1 (early sync): err pulse; partial frame discarded (no dataout update, no frame_valid); beat taken as slot 0: stg0<=din, sel<=1, miss_cnt<=0.
- Latency: frame_valid and the new dataout appear one clock after the slot-3 beat is sampled. All four channels update in the same edge, so dataout is never a mix of two frames.
- dataout holds its value between frames and through HUNT; it updates only on a complete frame.
- A frame completed with a flywheeled slot 0 still produces frame_valid.
- err is a one-cycle pulse per offending beat. Back-to-back errors produce back-to-back pulses.
- locked = (state==LOCK), registered. sel reflects the next expected slot; 0 in HUNT.
- miss_cnt width is ceil(log2(MISS_LIMIT+1)); no wrap possible.

Test Plan:
- Reset then 4 beats din=0x11,0x22,0x33,0x44 (fsync on first) -> locked=1 after beat 1; dataout=0x44332211 with frame_valid=1 exactly one cycle after beat 4; err never asserted.
- In HUNT, 3 beats without fsync then a synced frame 0xA0..0xA3 -> first 3 beats ignored, no err, dataout=0xA3A2A1A0.
- Locked; fsync asserted on slot 2 with din=0x55, then 0x66,0x77,0x88 -> err pulse on that beat, no frame_valid for the broken frame; next frame_valid gives dataout=0x88776655.
- Locked, MISS_LIMIT=3; three consecutive frames without fsync -> err pulses at each slot 0; frames 1 and 2 still deliver frame_valid; on the 3rd miss locked=0, sel=0, and dataout keeps its frame-2 value.
- din_valid gaps (idle cycles between beats) inside a frame -> sel holds during gaps, same dataout/frame_valid as with gapless input.
- rst_n=0 asserted mid-frame at sel=2 -> next cycle all outputs 0, HUNT; the partial frame is never emitted.
